// File: rtl/ef_apb_irq_pkg.sv
// Shared definitions for the APB-to-core bridge: FSM state type, local register
// offsets (PADDR[7:0] within region 0x0F) and the unmapped/timeout read pattern.
package ef_apb_irq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } core_state_e;

   localparam logic [7:0]  LocalRegion = 8'h0F;
   localparam logic [7:0]  OffRis      = 8'h04;
   localparam logic [7:0]  OffIm       = 8'h08;
   localparam logic [7:0]  OffMis      = 8'h0C;
   localparam logic [7:0]  OffIcr      = 8'h10;
   localparam logic [7:0]  OffEdge     = 8'h14;
   localparam logic [31:0] DeadBeef    = 32'hDEADBEEF;

endpackage

// File: rtl/ef_irq_flag_ctrl.sv
// Interrupt flag block: per-flag level/edge capture (RIS), mask (IM), W1C clear (ICR),
// masked status (MIS) and the registered interrupt output.
module ef_irq_flag_ctrl #(
   parameter int unsigned NUM_FLAGS = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_FLAGS-1:0] flags_i,
   input  logic                 im_we_i,
   input  logic                 edge_we_i,
   input  logic                 icr_we_i,
   input  logic [NUM_FLAGS-1:0] wdata_i,
   output logic [NUM_FLAGS-1:0] ris_o,
   output logic [NUM_FLAGS-1:0] im_o,
   output logic [NUM_FLAGS-1:0] edge_o,
   output logic [NUM_FLAGS-1:0] mis_o,
   output logic                 irq_o
);

   logic [NUM_FLAGS-1:0] im_q, im_d;
   logic [NUM_FLAGS-1:0] edge_mode_q, edge_mode_d;
   logic [NUM_FLAGS-1:0] sticky_q, sticky_d;
   logic [NUM_FLAGS-1:0] flags_prev_q;
   logic                 irq_q, irq_d;

   always_comb begin
      im_d        = im_q;
      edge_mode_d = edge_mode_q;
      sticky_d    = sticky_q;
      if (im_we_i)   im_d = wdata_i;
      if (edge_we_i) edge_mode_d = wdata_i;
      if (icr_we_i)  sticky_d = sticky_d & ~wdata_i;
      if (edge_we_i) sticky_d = sticky_d & ~(edge_mode_q ^ wdata_i);
      // Applied last so a new edge beats a coincident ICR clear.
      sticky_d = sticky_d | (flags_i & ~flags_prev_q & edge_mode_q);

      ris_o  = (edge_mode_q & sticky_q) | (~edge_mode_q & flags_i);
      mis_o  = ris_o & im_q;
      im_o   = im_q;
      edge_o = edge_mode_q;
      irq_d  = |mis_o;
      irq_o  = irq_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         im_q         <= '0;
         edge_mode_q  <= '0;
         sticky_q     <= '0;
         flags_prev_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         im_q         <= im_d;
         edge_mode_q  <= edge_mode_d;
         sticky_q     <= sticky_d;
         flags_prev_q <= flags_i;
         irq_q        <= irq_d;
      end
   end

endmodule

// File: rtl/ef_apb_irq_bridge.sv
// APB slave bridging to a Wishbone-style core plus a local interrupt register block.
// Define EF_APB_IRQ_BRIDGE_TIMEOUT_EN to add a core-ack timeout that answers with PSLVERR.
module ef_apb_irq_bridge
   import ef_apb_irq_pkg::*;
#(
   parameter int unsigned NUM_FLAGS   = 9,
   parameter int unsigned CORE_DW     = 16,
   parameter int unsigned CORE_AW     = 3,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [15:0]          PADDR,
   input  logic [31:0]          PWDATA,
   output logic [31:0]          PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic [CORE_AW-1:0]   core_adr_o,
   output logic [CORE_DW-1:0]   core_dat_o,
   input  logic [CORE_DW-1:0]   core_dat_i,
   output logic                 core_we_o,
   output logic                 core_stb_o,
   output logic                 core_cyc_o,
   input  logic                 core_ack_i,
   input  logic [NUM_FLAGS-1:0] flags_i,
   output logic                 irq_o
);

   core_state_e          state_q, state_d;
   logic [CORE_AW-1:0]   adr_q, adr_d;
   logic [CORE_DW-1:0]   dat_q, dat_d;
   logic                 we_q, we_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 access, local_sel, local_req, local_wr;
   logic [7:0]           offset;
   logic [31:0]          local_rdata;
   logic [NUM_FLAGS-1:0] ris, im, edge_mode, mis;
   logic                 unused_pwdata;

`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`endif

   assign access        = PSEL & PENABLE;
   assign local_sel     = (PADDR[15:8] == LocalRegion);
   assign offset        = PADDR[7:0];
   assign local_req     = access & local_sel & (state_q == StIdle);
   assign local_wr      = local_req & PWRITE;
   assign unused_pwdata = ^PWDATA;

   ef_irq_flag_ctrl #(
      .NUM_FLAGS(NUM_FLAGS)
   ) u_flag_ctrl (
      .clk_i    (PCLK),
      .rst_i    (PRESET),
      .flags_i  (flags_i),
      .im_we_i  (local_wr && offset == OffIm),
      .edge_we_i(local_wr && offset == OffEdge),
      .icr_we_i (local_wr && offset == OffIcr),
      .wdata_i  (PWDATA[NUM_FLAGS-1:0]),
      .ris_o    (ris),
      .im_o     (im),
      .edge_o   (edge_mode),
      .mis_o    (mis),
      .irq_o    (irq_o)
   );

   always_comb begin
      local_rdata = DeadBeef;
      case (offset)
         OffRis:  local_rdata = 32'(ris);
         OffIm:   local_rdata = 32'(im);
         OffMis:  local_rdata = 32'(mis);
         OffIcr:  local_rdata = '0;
         OffEdge: local_rdata = 32'(edge_mode);
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      rdata_d = rdata_q;
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (access && !local_sel) begin
               state_d = StWait;
               adr_d   = PADDR[CORE_AW:1];
               dat_d   = PWDATA[CORE_DW-1:0];
               we_d    = PWRITE;
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
               cnt_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         StWait: begin
            if (core_ack_i) begin
               state_d = StResp;
               rdata_d = 32'(core_dat_i);
               we_d    = 1'b0;
            end
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               state_d = StResp;
               rdata_d = DeadBeef;
               we_d    = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      core_adr_o = adr_q;
      core_dat_o = dat_q;
      core_we_o  = we_q;
      core_stb_o = (state_q == StWait);
      core_cyc_o = (state_q == StWait);
      PREADY     = access & (local_req | (state_q == StResp));
      PRDATA     = (state_q == StResp) ? rdata_q : local_rdata;
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
      PSLVERR    = access & (state_q == StResp) & err_q;
`else
      PSLVERR    = 1'b0;
`endif
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= StIdle;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_ef_apb_irq_bridge.sv
// Directed bench for ef_apb_irq_bridge: APB read data is checked through a scoreboard
// queue; interrupt, wait-state and core-handshake behaviour is checked inline.
module tb_ef_apb_irq_bridge;

`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic [2:0]  core_adr_o;
   logic [15:0] core_dat_o, core_dat_i;
   logic        core_we_o, core_stb_o, core_cyc_o, core_ack_i;
   logic [8:0]  flags_i;
   logic        irq_o;

   ef_apb_irq_bridge #(
      .NUM_FLAGS  (9),
      .CORE_DW    (16),
      .CORE_AW    (3),
      .TIMEOUT_CYC(TO)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .core_adr_o(core_adr_o),
      .core_dat_o(core_dat_o),
      .core_dat_i(core_dat_i),
      .core_we_o (core_we_o),
      .core_stb_o(core_stb_o),
      .core_cyc_o(core_cyc_o),
      .core_ack_i(core_ack_i),
      .flags_i   (flags_i),
      .irq_o     (irq_o)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      string       tag;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_assert = 0;
   int          n_fail = 0;
   int          ack_delay = 3;
   bit          ack_en = 1'b1;
   logic [15:0] ack_data = 16'h0;
   logic [2:0]  seen_adr = '0;
   logic [15:0] seen_dat = '0;
   logic        seen_we = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Core model: acks the ack_delay-th cycle of a request, capturing what the DUT drove.
   initial begin : core_resp
      int cnt;
      cnt = 0;
      core_ack_i = 1'b0;
      core_dat_i = '0;
      forever begin
         @(negedge PCLK);
         if (core_stb_o && ack_en) begin
            cnt++;
            seen_adr = core_adr_o;
            seen_dat = core_dat_o;
            seen_we  = core_we_o;
            if (cnt == ack_delay) begin
               core_ack_i = 1'b1;
               core_dat_i = ack_data;
            end else begin
               core_ack_i = 1'b0;
            end
         end else begin
            cnt = 0;
            core_ack_i = 1'b0;
         end
      end
   end

   task automatic xfer(input logic [15:0] addr, input logic [31:0] wdata, input logic write,
                       input logic [8:0] flag_pulse, output int waits, output logic err);
      bit   done;
      exp_t e;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = write; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      flags_i = flags_i | flag_pulse;
      waits = 0; done = 1'b0; err = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         @(negedge PCLK);
         if (PREADY) begin
            done = 1'b1;
            err  = PSLVERR;
            if (!write && sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk(e.tag, PRDATA, e.data);
            end
         end else begin
            waits++;
         end
      end
      chk("xfer_done", 32'(done), 32'd1);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic apb_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [8:0] flag_pulse, output int waits, output logic err);
      xfer(addr, data, 1'b1, flag_pulse, waits, err);
   endtask

   task automatic apb_read(input string tag, input logic [15:0] addr, input logic [31:0] exp,
                           output int waits, output logic err);
      sb_q.push_back('{tag, exp});
      xfer(addr, 32'h0, 1'b0, 9'h0, waits, err);
   endtask

   initial begin : main
      int   w;
      logic e;
      bit   rdy_seen;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      flags_i = '0;
      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_stb", 32'(core_stb_o), 32'd0);
      chk("rst_cyc", 32'(core_cyc_o), 32'd0);
      chk("rst_we", 32'(core_we_o), 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      apb_read("rst_im", 16'h0F08, 32'h0, w, e);
      chk("local_waits", 32'(w), 32'd0);
      apb_read("rst_edge", 16'h0F14, 32'h0, w, e);
      apb_read("rst_ris", 16'h0F04, 32'h0, w, e);

      // Level mode: IM bit 0, upper PWDATA bits discarded.
      apb_write(16'h0F08, 32'h0000FE01, 9'h0, w, e);
      apb_read("im_trunc", 16'h0F08, 32'h001, w, e);
      apb_write(16'h0F14, 32'h0, 9'h0, w, e);
      @(posedge PCLK); #1;
      flags_i = 9'h001;
      @(negedge PCLK);
      chk("irq_lat0", 32'(irq_o), 32'd0);
      @(negedge PCLK);
      chk("irq_level", 32'(irq_o), 32'd1);
      apb_read("ris_level", 16'h0F04, 32'h001, w, e);
      apb_read("mis_level", 16'h0F0C, 32'h001, w, e);
      flags_i = 9'h000;
      @(negedge PCLK);
      chk("irq_hold", 32'(irq_o), 32'd1);
      @(negedge PCLK);
      chk("irq_drop", 32'(irq_o), 32'd0);

      // Edge mode on flag 1.
      apb_write(16'h0F08, 32'h003, 9'h0, w, e);
      apb_write(16'h0F14, 32'h002, 9'h0, w, e);
      apb_read("edge_rd", 16'h0F14, 32'h002, w, e);
      @(posedge PCLK); #1;
      flags_i = 9'h002;
      @(posedge PCLK); #1;
      flags_i = 9'h000;
      repeat (2) @(negedge PCLK);
      chk("irq_edge", 32'(irq_o), 32'd1);
      apb_read("ris_sticky", 16'h0F04, 32'h002, w, e);
      apb_read("icr_rd0", 16'h0F10, 32'h0, w, e);
      apb_write(16'h0F10, 32'h002, 9'h0, w, e);
      apb_read("ris_cleared", 16'h0F04, 32'h0, w, e);
      chk("irq_cleared", 32'(irq_o), 32'd0);
      apb_write(16'h0F10, 32'h002, 9'h002, w, e);
      flags_i = 9'h000;
      apb_read("ris_set_wins", 16'h0F04, 32'h002, w, e);
      apb_read("mis_set_wins", 16'h0F0C, 32'h002, w, e);
      apb_write(16'h0F14, 32'h000, 9'h0, w, e);
      apb_write(16'h0F14, 32'h002, 9'h0, w, e);
      apb_read("ris_mode_clr", 16'h0F04, 32'h0, w, e);

      // Unmapped local address.
      apb_read("unmapped", 16'h0F20, 32'hDEADBEEF, w, e);
      chk("unmapped_waits", 32'(w), 32'd0);
      chk("unmapped_err", 32'(e), 32'd0);
      apb_write(16'h0F20, 32'hFFFFFFFF, 9'h0, w, e);
      apb_read("im_after_unm", 16'h0F08, 32'h003, w, e);

      // Core read, ack on the third WAIT cycle.
      ack_delay = 3; ack_data = 16'hA5A5;
      apb_read("core_rd", 16'h0004, 32'h0000A5A5, w, e);
      chk("core_rd_waits", 32'(w), 32'd4);
      chk("core_rd_err", 32'(e), 32'd0);
      chk("core_rd_adr", 32'(seen_adr), 32'd2);
      chk("core_rd_we", 32'(seen_we), 32'd0);
      chk("core_rd_stb_end", 32'(core_stb_o), 32'd0);

      // Core write, ack on the first WAIT cycle.
      ack_delay = 1;
      apb_write(16'h0006, 32'h12345678, 9'h0, w, e);
      chk("core_wr_waits", 32'(w), 32'd2);
      chk("core_wr_adr", 32'(seen_adr), 32'd3);
      chk("core_wr_dat", 32'(seen_dat), 32'h5678);
      chk("core_wr_we", 32'(seen_we), 32'd1);

`ifdef EF_APB_IRQ_BRIDGE_TIMEOUT_EN
      ack_en = 1'b0;
      apb_read("timeout_rd", 16'h0010, 32'hDEADBEEF, w, e);
      chk("timeout_waits", 32'(w), 32'd9);
      chk("timeout_err", 32'(e), 32'd1);
      ack_en = 1'b1;
      ack_delay = 8; ack_data = 16'h1357;
      apb_read("ack_vs_to", 16'h0010, 32'h00001357, w, e);
      chk("ack_vs_to_waits", 32'(w), 32'd9);
      chk("ack_vs_to_err", 32'(e), 32'd0);
`endif

      // Reset while the core request is outstanding.
      ack_en = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0020; PWRITE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      chk("wait_stb", 32'(core_stb_o), 32'd1);
      @(posedge PCLK); #1;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      rdy_seen = 1'b0;
      @(negedge PCLK);
      chk("rst_wait_stb", 32'(core_stb_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         rdy_seen = rdy_seen | PREADY;
         @(negedge PCLK);
      end
      chk("rst_wait_pready", 32'(rdy_seen), 32'd0);
      ack_en = 1'b1;

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ef_apb_irq_bridge.md
EF_APB_IRQ_BRIDGE -- requirements
Module: ef_apb_irq_bridge

Interface
REQ-001 Parameter NUM_FLAGS, default 9: number of core status flags handled for interrupts, range 1..32.
REQ-002 Parameter CORE_DW, default 16: core data-bus width, range 8..32.
REQ-003 Parameter CORE_AW, default 3: core word-address width, taken from PADDR[CORE_AW:1].
REQ-004 Parameter TIMEOUT_CYC, default 255: maximum cycles spent waiting for core_ack_i; 8-bit counter.
REQ-005 Ports, listed as name, direction, width, meaning:
- PCLK  in  1  the single clock.
- PRESET  in  1  synchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1  APB control.
- PADDR  in  16  APB address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB transfer complete.
- PSLVERR  out  1  APB error.
- core_adr_o  out  CORE_AW  core word address.
- core_dat_o  out  CORE_DW  core write data.
- core_dat_i  in  CORE_DW  core read data.
- core_we_o, core_stb_o, core_cyc_o  out  1  Wishbone-style request.
- core_ack_i  in  1  core acknowledge.
- flags_i  in  NUM_FLAGS  core status flags.
- irq_o  out  1  interrupt.

Function
REQ-006 PADDR[15:8]==0x0F SHALL select the local register region; every other address SHALL select the core.
REQ-007 Local register map: 0xF04 RIS (read-only), 0xF08 IM (read/write), 0xF0C MIS (read-only), 0xF10 ICR (write-1-to-clear, reads 0), 0xF14 EDGE (read/write; per-flag mode, 1=edge, 0=level).
REQ-008 A local access SHALL assert PREADY in the first access cycle (PSEL&PENABLE), with no wait states.
REQ-009 An unmapped local address SHALL read 0xDEADBEEF, ignore writes, and complete with PREADY=1 and PSLVERR=0.
REQ-010 The core-access FSM SHALL have states IDLE, WAIT and RESP.
REQ-011 IDLE->WAIT on PSEL&PENABLE to the core region; in WAIT, core_cyc_o=core_stb_o=1 and address, data and we are registered from the APB request.
REQ-012 WAIT->RESP on core_ack_i; core_dat_i SHALL be latched zero-extended to 32 bits; stb and cyc SHALL drop in the same cycle.
REQ-013 RESP SHALL assert PREADY for exactly one cycle with the latched PRDATA, then return to IDLE.
REQ-014 While PREADY=0, PRDATA is don't-care; PREADY SHALL never be asserted outside PSEL&PENABLE.
REQ-015 Level-mode flag: RIS[i] = flags_i[i] (live).
REQ-016 Edge-mode flag: a registered 0->1 edge on flags_i[i] SHALL set sticky RIS[i]; a write of 1 to ICR[i] SHALL clear it; if set and clear occur in the same cycle, set wins.
REQ-017 Writing EDGE SHALL clear sticky RIS bits whose mode changes.
REQ-018 MIS = RIS & IM; irq_o SHALL be registered as |MIS, giving one cycle of latency from an RIS/IM change.
REQ-019 Register widths: IM, EDGE, RIS and MIS are NUM_FLAGS bits wide and read zero-extended to 32 bits; PWDATA bits above NUM_FLAGS are ignored.

Reset
REQ-020 On PRESET=1 at a PCLK edge: FSM=IDLE; IM, EDGE and sticky RIS = 0; flag history = 0; PREADY=0; PSLVERR=0; irq_o=0; core_stb_o=core_cyc_o=core_we_o=0; timeout counter=0.
REQ-021 A reset asserted during WAIT SHALL abandon the core access with no PREADY issued.

Configuration
REQ-022 Macro EF_APB_IRQ_BRIDGE_TIMEOUT_EN, when defined: a counter runs in WAIT; on reaching TIMEOUT_CYC without ack, the block SHALL go to RESP with PSLVERR=1 and PRDATA=0xDEADBEEF, dropping stb and cyc; ack and timeout in the same cycle SHALL count as ack.
REQ-023 When EF_APB_IRQ_BRIDGE_TIMEOUT_EN is undefined: no counter; WAIT is held until ack; PSLVERR is tied to 0.

Structure
REQ-024 Shared package ef_apb_irq_pkg SHALL hold the FSM state typedef, the local address constants, and the 0xDEADBEEF constant.
REQ-025 Sub-module ef_irq_flag_ctrl SHALL contain the RIS/IM/EDGE/ICR/MIS logic and the irq_o register; the top level contains the APB decode and the FSM.

Verification
REQ-026 Write IM=0x001, EDGE=0; drive flags_i[0]=1 -> RIS=0x001, MIS=0x001, irq_o=1 one cycle later; drop flag -> irq_o=0.
REQ-027 EDGE=0x002; pulse flags_i[1] for 1 cycle -> RIS[1] stays 1; write ICR=0x002 -> RIS=0; ICR write coincident with a new edge -> RIS[1]=1.
REQ-028 Read core address 0x0004 with core_ack_i after 3 cycles and core_dat_i=0xA5A5 -> PREADY one cycle after ack, PRDATA=0x0000A5A5, core_adr_o=2.
REQ-029 With the macro defined and TIMEOUT_CYC=8, core never acks -> PREADY and PSLVERR high 8 cycles after entering WAIT, PRDATA=0xDEADBEEF.
REQ-030 Read 0xF20 -> 0xDEADBEEF with zero wait states; PRESET pulsed during WAIT -> FSM IDLE, stb=0, no PREADY.
